uart_tx_frame: RTL



---
 rtl/uart_tx_frame.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer: start, data LSB first, optional parity, stop.
// Outputs are registered from the next-state decode, so the start bit leaves on the accepting edge.
module uart_tx_frame #(
  parameter int data_width = 8
) (
  input  logic                  clk_TX,
  input  logic                  rst,
  input  logic [data_width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [data_width-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;

  always_ff @(posedge clk_TX or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          tx_d  = data_q[cnt_d];
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        // Busy drops together with the line returning to idle.
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
